regbank_arbiter: RTL
====================

# regbank_arbiter

Round-robin arbiter and sequencer that shares a bank of W-bit storage registers between N_REQ requesters. Each requester issues a single read or write to one register. The block serializes the requests, performs each access and returns an acknowledge with read data. It sits between the datapath masters and the register storage and owns all register state.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 8, register data width
- DEPTH, 4, number of registers; power of 2, ≥2
- AW, $clog2(DEPTH), address width (derived; not overridden)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- Req  in  N_REQ  per-requester request, level
- Wr  in  N_REQ  per-requester op: 1 = write, 0 = read
- Addr  in  N_REQ*AW  per-requester register address; requester i uses bits [i*AW +: AW]
- Din  in  N_REQ*W  per-requester write data; requester i uses bits [i*W +: W]
- Gnt  out  N_REQ  one-hot grant, held for the whole transaction
- Ack  out  1  one-cycle completion pulse for the granted requester
- Dout  out  W  read data; valid while Ack=1, holds until the next read completes
- Busy  out  1  high in any state other than IDLE

## Operation
- Storage is DEPTH × W registers, internal to the block. Only this block writes them.
- States:
  - IDLE: if |Req, pick the winner, set Gnt to one-hot(winner) and latch Wr, Addr and Din of the winner, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: if the latched op is a write, mem[addr] <= din. If it is a read, Dout <= mem[addr]. In both cases set Ack <= 1 and go to ACK.
  - ACK: Ack <= 0, Gnt <= 0, ptr <= (winner+1) mod N_REQ, go to IDLE.
- Arbitration is round-robin. Search starts at ptr and goes up in index, wrapping mod N_REQ. The first set Req bit wins.
- Command is latched at the grant edge:
  - Changes to Req, Wr, Addr or Din of the winner after that edge are ignored.
  - Dropping Req mid-transaction does not abort it.
- A requester that keeps Req high after Ack is re-eligible in the next IDLE cycle. It has the lowest priority there, because ptr has moved past it.
- On a write, Dout is unchanged.
- Reset (Rst=1 at an edge), from any state:
  - state = IDLE, ptr = 0, Gnt = 0, Ack = 0, Busy = 0, Dout = 0, all registers = 0.
  - Rst takes priority over every other update in the same cycle. Reset in ACCESS performs no write and no Ack.

## Timing
- Request sampled in IDLE at edge T: Gnt and Busy high after T.
- Access performed at T+1: Ack high and Dout valid after T+1.
- Gnt, Ack and Busy low after T+2. Next arbitration happens at T+3 at the earliest.
- Throughput is one transaction per 3 cycles. Latency from Req sampled to Ack is 2 cycles.
- A read at T+1 returns register contents as of T+1, including any write completed in an earlier transaction.
- At most one Gnt bit is ever high. Ack is never high without Gnt.
- Addr wrap: addresses are exactly AW bits, so every address maps to a valid register. No out-of-range case exists.

## Test plan
- **Reset:** hold Rst=1 for 2 cycles with random Req. Require Gnt=0, Ack=0, Busy=0, Dout=00. A subsequent read of each of addresses 0..3 returns 00.
- **Write/read, single requester:** req1 writes 8'h35 to addr 2. Require Gnt=4'b0010 one cycle after sampling and Ack on the following cycle. Then req1 reads addr 2: Dout=8'h35 with Ack.
- **Round-robin fairness:** all four Req held high continuously with ptr=0. Required grant order is 0,1,2,3,0, each Gnt lasting 2 cycles with 1 idle cycle between.
- **Simultaneous requests after rotation:** after a grant to 2, assert Req=4'b0101. Next grant goes to 0, and Gnt=4'b0001.
- **Latched command:** req3 is granted to write 8'hA5 to addr 3. Change Din to 8'hFF and drop Req during ACCESS. A readback of addr 3 returns 8'hA5.
- **Reset mid-operation:** req0 write of 8'h77 to addr 1, with Rst=1 on the ACCESS edge. Require Ack never asserted and addr 1 reads 00 afterwards.

Source files
------------

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Shares a bank of DEPTH x W registers between N_REQ requesters. Each
//   transaction is one read or write. A round-robin pick happens in IDLE, the
//   access happens in ACCESS, and ACK releases the grant. That gives one
//   transaction every 3 cycles.
// Ports
//   Clk, Rst     : clock, synchronous active-high reset
//   Req/Wr       : per-requester request level and op (1 = write)
//   Addr/Din     : per-requester address (AW bits each) and write data (W bits each)
//   Gnt          : one-hot grant, held for the whole transaction
//   Ack          : one-cycle completion pulse
//   Dout         : read data, held until the next read completes
//   Busy         : high whenever the sequencer is not in IDLE
module regbank_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N_REQ-1:0]   Req,
  input  logic [N_REQ-1:0]   Wr,
  input  logic [N_REQ*AW-1:0] Addr,
  input  logic [N_REQ*W-1:0] Din,
  output logic [N_REQ-1:0]   Gnt,
  output logic               Ack,
  output logic [W-1:0]       Dout,
  output logic               Busy
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [PW-1:0]             win_q, win_d;
  logic [N_REQ-1:0]          gnt_q, gnt_d;
  logic                      ack_q, ack_d;
  logic [W-1:0]              dout_q, dout_d;
  logic                      wr_q, wr_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [W-1:0]              din_q, din_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;

  // Round-robin search: first set Req at or above ptr, wrapping mod N_REQ.
  logic          arb_found;
  logic [PW-1:0] arb_win;
  int            arb_idx;

  always_comb begin
    arb_found = 1'b0;
    arb_win   = ptr_q;
    arb_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_idx = (int'(ptr_q) + k) % N_REQ;
      if (!arb_found && Req[arb_idx]) begin
        arb_found = 1'b1;
        arb_win   = PW'(arb_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          // Command is captured here so later input changes cannot affect it.
          gnt_d          = '0;
          gnt_d[arb_win] = 1'b1;
          win_d          = arb_win;
          wr_d           = Wr[arb_win];
          addr_d         = Addr[int'(arb_win)*AW +: AW];
          din_d          = Din[int'(arb_win)*W +: W];
          state_d        = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (wr_q) mem_d[addr_q] = din_q;
        else      dout_d        = mem_q[addr_q];
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        ack_d   = 1'b0;
        gnt_d   = '0;
        // The winner drops to lowest priority for the next pick.
        ptr_d   = (win_q == PW'(N_REQ-1)) ? '0 : win_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mem_q   <= mem_d;
    end
  end

  assign Gnt  = gnt_q;
  assign Ack  = ack_q;
  assign Dout = dout_q;
  assign Busy = (state_q != S_IDLE);

endmodule
